// File: rtl/mul_pipe_pkg.sv
// Shared constants and result record for the multiplier pipeline and its frame collector.
package mul_pipe_pkg;

    localparam int MUL_LAT   = 3;
    localparam int PROD_W    = 16;
    localparam int RES_ACC_W = 24;
    localparam int RES_CNT_W = 10;

    // One queued frame result; field widths track the collector's ACC_W/CNT_W defaults.
    typedef struct packed {
        logic [RES_ACC_W-1:0] data;
        logic [RES_CNT_W-1:0] count;
        logic                 sat;
    } res_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry register FIFO, first-word-fall-through from slot0.
// A push with the FIFO full and no pop is dropped and reported on drop_o.
module result_fifo2 #(
    parameter int W = 35
) (
    input  logic         mod_clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         drop_o
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop_ok;
    logic         push_ok;
    logic         drop;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        pop_ok  = pop_i && (cnt_q != 2'd0);
        drop    = push_i && (cnt_q == 2'd2) && !pop_ok;
        push_ok = push_i && !drop;
        case ({push_ok, pop_ok})
            2'b01: begin
                slot0_d = slot1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) slot0_d = push_data_i;
                else               slot1_d = push_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b11: begin
                // Count unchanged; with one entry the new item becomes the head.
                if (cnt_q == 2'd1) begin
                    slot0_d = push_data_i;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge mod_clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign head_o  = slot0_q;
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign drop_o  = drop;

endmodule

// File: rtl/mul_acc_frame_collector.sv
// Re-aligns operand flags to the non-stallable multiplier's product stream, accumulates
// each frame into a dot product and queues frame results on a valid/ready output.
module mul_acc_frame_collector #(
    parameter int MUL_LAT = mul_pipe_pkg::MUL_LAT,
    parameter int ACC_W   = mul_pipe_pkg::RES_ACC_W,
    parameter int CNT_W   = mul_pipe_pkg::RES_CNT_W
) (
    input  logic             mod_clk,
    input  logic             rst_n,
    input  logic             op_valid_i,
    input  logic             op_last_i,
    input  logic [15:0]      prod_i,
    output logic [ACC_W-1:0] res_data_o,
    output logic [CNT_W-1:0] res_count_o,
    output logic             res_sat_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             ovf_err_o,
    input  logic             clr_err_i
);

    import mul_pipe_pkg::*;

    logic [MUL_LAT-1:0] pv_q;
    logic [MUL_LAT-1:0] pl_q;
    logic               pv;
    logic               pl;

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               frame_start_q, frame_start_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   acc_base;
    logic [CNT_W-1:0]   cnt_base;
    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   acc_sum;
    logic [CNT_W-1:0]   cnt_sum;
    logic               sat_sum;

    res_t               push_rec;
    res_t               head_rec;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_drop;

    // op_last is only meaningful alongside op_valid, so it is qualified before delaying.
    always_ff @(posedge mod_clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            pl_q <= '0;
        end else begin
            pv_q[0] <= op_valid_i;
            pl_q[0] <= op_valid_i && op_last_i;
            for (int i = 1; i < MUL_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pl_q[i] <= pl_q[i-1];
            end
        end
    end

    assign pv = pv_q[MUL_LAT-1];
    assign pl = pl_q[MUL_LAT-1];

    always_comb begin
        acc_base = frame_start_q ? '0 : acc_q;
        cnt_base = frame_start_q ? '0 : cnt_q;
        sum_wide = {1'b0, acc_base} + {{(ACC_W+1-PROD_W){1'b0}}, prod_i};
        acc_sum  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
        sat_sum  = sum_wide[ACC_W] || (!frame_start_q && sat_q);
        cnt_sum  = (&cnt_base) ? cnt_base : cnt_base + 1'b1;

        acc_d         = acc_q;
        cnt_d         = cnt_q;
        sat_d         = sat_q;
        frame_start_d = frame_start_q;
        if (pv) begin
            acc_d         = acc_sum;
            cnt_d         = cnt_sum;
            sat_d         = sat_sum;
            frame_start_d = pl;
        end

        // A drop in the same cycle as a clear leaves the error set.
        ovf_d = ovf_q;
        if (fifo_drop)      ovf_d = 1'b1;
        else if (clr_err_i) ovf_d = 1'b0;
    end

    always_ff @(posedge mod_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q         <= '0;
            cnt_q         <= '0;
            sat_q         <= 1'b0;
            frame_start_q <= 1'b1;
            ovf_q         <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            sat_q         <= sat_d;
            frame_start_q <= frame_start_d;
            ovf_q         <= ovf_d;
        end
    end

    always_comb begin
        push_rec.data  = acc_sum;
        push_rec.count = cnt_sum;
        push_rec.sat   = sat_sum;
    end

    result_fifo2 #(
        .W ($bits(res_t))
    ) u_fifo (
        .mod_clk     (mod_clk),
        .rst_n       (rst_n),
        .push_i      (pv && pl),
        .push_data_i (push_rec),
        .pop_i       (res_ready_i),
        .head_o      (head_rec),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .drop_o      (fifo_drop)
    );

    assign res_data_o  = head_rec.data;
    assign res_count_o = head_rec.count;
    assign res_sat_o   = head_rec.sat;
    assign res_valid_o = !fifo_empty;
    assign ovf_err_o   = ovf_q;

endmodule
